// File: rtl/alu_mul_seq.sv
// ============================================================================
// Module   : alu_mul_seq
// Brief    : Shift-and-add unsigned multiply sequencer driving a shared ALU.
//            Optional zero-operand shortcut under macro MUL_ZERO_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_seq #(
    parameter int         WIDTH    = 16,
    parameter logic [2:0] ADD_CODE = 3'b000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_code,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_carry
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_LAST_STEP = 5'(WIDTH - 1);

    state_t           r_state;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_bypass;

`ifdef MUL_ZERO_BYPASS_EN
    assign w_bypass = (op_a == '0) || (op_b == '0);
`else
    assign w_bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= op_a;
                        r_cnt    <= 5'd0;
                        r_acc_hi <= '0;
                        r_ready  <= 1'b0;
                        if (w_bypass) begin
                            r_acc_lo <= '0;
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                        end else begin
                            r_acc_lo <= op_b;
                            r_state  <= S_STEP;
                            r_busy   <= 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    // Carry-out becomes the new MSB so the product never overflows.
                    {r_acc_hi, r_acc_lo} <= {alu_carry, alu_out, r_acc_lo[WIDTH-1:1]};
                    if (r_cnt == c_LAST_STEP) begin
                        r_cnt   <= 5'd0;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 5'd0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign product  = {r_acc_hi, r_acc_lo};
    assign alu_a    = r_busy ? r_acc_hi : '0;
    assign alu_b    = (r_busy && r_acc_lo[0]) ? r_mcand : '0;
    assign alu_code = ADD_CODE;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// ============================================================================
// Module   : tb_alu_mul_seq
// Brief    : Self-checking bench for alu_mul_seq with a cycle-timing model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mul_seq;

    localparam logic [2:0] c_ADD = 3'b000;

`ifdef MUL_ZERO_BYPASS_EN
    localparam int c_ZLAT  = 1;
    localparam int c_ZBUSY = 0;
`else
    localparam int c_ZLAT  = 17;
    localparam int c_ZBUSY = 16;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        ready, busy, done;
    logic [31:0] product;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_code;
    logic        alu_carry;
    logic [16:0] w_sum;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.WIDTH(16), .ADD_CODE(c_ADD)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .ready(ready), .busy(busy), .done(done), .product(product),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
        .alu_out(alu_out), .alu_carry(alu_carry)
    );

    // Shared ALU: plain 17-bit add for the add opcode
    assign w_sum     = (alu_code == c_ADD) ? ({1'b0, alu_a} + {1'b0, alu_b}) : 17'd0;
    assign alu_out   = w_sum[15:0];
    assign alu_carry = w_sum[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timing model: phase 0 idle, 1..16 stepping, 17 done pulse
    int          m_phase = 0;
    logic [31:0] m_prod  = '0;
    logic [15:0] m_a     = '0;
    logic        m_valid = 1'b0;

    function automatic logic zero_bypass(input logic [15:0] a, input logic [15:0] b);
`ifdef MUL_ZERO_BYPASS_EN
        return (a == 16'd0) || (b == 16'd0);
`else
        return 1'b0 & (a[0] | b[0]);
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_prod  <= '0;
            m_valid <= 1'b1;
        end else if (m_phase == 0) begin
            if (start) begin
                m_a     <= op_a;
                m_prod  <= 32'(op_a) * 32'(op_b);
                m_phase <= zero_bypass(op_a, op_b) ? 17 : 1;
            end
        end else if (m_phase == 17) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready", 64'(ready), 64'(m_phase == 0));
            chk("busy",  64'(busy),  64'(m_phase >= 1 && m_phase <= 16));
            chk("done",  64'(done),  64'(m_phase == 17));
            chk("alu_code", 64'(alu_code), 64'(c_ADD));
            if (m_phase == 0 || m_phase == 17)
                chk("product", 64'(product), 64'(m_prod));
            if (m_phase >= 1 && m_phase <= 16) begin
                chk("alu_b_sel", 64'(alu_b == 16'd0 || alu_b == m_a), 64'd1);
            end else begin
                chk("alu_a_idle", 64'(alu_a), 64'd0);
                chk("alu_b_idle", 64'(alu_b), 64'd0);
            end
        end
    end

    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp_p, input int exp_lat,
                           input int exp_busy, input string nm);
        int lat = 0;
        int nb  = 0;
        logic [31:0] p = '0;
        @(negedge clk);
        for (int w = 0; w < 40 && !ready; w++) @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) nb++;
            if (done) begin
                lat = c;
                p   = product;
                break;
            end
        end
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, " product"}, 64'(p), 64'(exp_p));
        chk({nm, " busy cycles"}, 64'(nb), 64'(exp_busy));
    endtask

    initial begin
        int lat;
        int nd;
        int d_at[2];
        logic [31:0] d_p[2];

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst ready",   64'(ready),   64'd1);
        chk("rst busy",    64'(busy),    64'd0);
        chk("rst done",    64'(done),    64'd0);
        chk("rst product", 64'(product), 64'd0);
        chk("rst alu_a",   64'(alu_a),   64'd0);
        chk("rst alu_b",   64'(alu_b),   64'd0);

        run_mul(16'd3, 16'd5, 32'h0000_000F, 17, 16, "3x5");
        run_mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17, 16, "max");
        run_mul(16'h8001, 16'h0003, 32'h0001_8003, 17, 16, "mix");

        // Start raised mid-multiply must not recapture operands
        @(negedge clk);
        start = 1'b1; op_a = 16'h1234; op_b = 16'h0002;
        @(posedge clk);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 4) begin start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; end
            if (c == 10) start = 1'b0;
            if (done) begin
                lat = c;
                chk("ignore product", 64'(product), 64'h0000_2468);
                break;
            end
        end
        chk("ignore latency", 64'(lat), 64'd17);
        repeat (2) @(negedge clk);
        chk("ignore back idle", 64'(ready), 64'd1);

        // Reset in the middle of a multiply
        start = 1'b1; op_a = 16'h1234; op_b = 16'h5678;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst ready",   64'(ready),   64'd1);
        chk("midrst busy",    64'(busy),    64'd0);
        chk("midrst product", 64'(product), 64'd0);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("midrst no done", 64'(nd), 64'd0);
        run_mul(16'd7, 16'd9, 32'h0000_003F, 17, 16, "7x9");

        // Start held high: accepts every 18 cycles, never during DONE
        @(negedge clk);
        start = 1'b1; op_a = 16'h0100; op_b = 16'h0100;
        @(posedge clk);
        nd = 0;
        for (int c = 1; c <= 60 && nd < 2; c++) begin
            @(negedge clk);
            if (done) begin
                d_at[nd] = c;
                d_p[nd]  = product;
                nd++;
                if (nd == 2) start = 1'b0;
            end
        end
        chk("b2b done count", 64'(nd), 64'd2);
        chk("b2b first done", 64'(d_at[0]), 64'd17);
        chk("b2b spacing",    64'(d_at[1] - d_at[0]), 64'd18);
        chk("b2b product0",   64'(d_p[0]), 64'h0001_0000);
        chk("b2b product1",   64'(d_p[1]), 64'h0001_0000);
        repeat (2) @(negedge clk);

        run_mul(16'd0, 16'h1234, 32'h0, c_ZLAT, c_ZBUSY, "zero");
        run_mul(16'hABCD, 16'd0, 32'h0, c_ZLAT, c_ZBUSY, "zero_b");
        run_mul(16'd1, 16'hFFFF, 32'h0000_FFFF, 17, 16, "1xmax");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
